// File: rtl/pipe_issue_arbiter_if.sv
// Requester-side handshake bundle for the issue arbiter.
// Master drives valid/inst; the arbiter (slave) drives ready.
interface pipe_issue_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_inst;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_inst;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_inst, req1_valid, req1_inst,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_inst, req1_valid, req1_inst,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue arbiter feeding the 4-register pipeline; pipe_inst lags a grant by 1 cycle, done by 3.
// Ready is combinational from the valids (one grant per cycle) and is withheld in DRAIN/IDLE and during reset.
module pipe_issue_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_issue_arbiter_if.slave  bus,
  input  logic                 drain,
  output logic [7:0]           pipe_inst,
  output logic [1:0]           done,
  output logic                 idle,
  output logic [1:0]           inflight,
  output logic [CNT_W-1:0]     issued0_cnt,
  output logic [CNT_W-1:0]     issued1_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

  state_t           r_state;
  logic             r_idle;
  logic             r_prio;
  logic [7:0]       r_pipe_inst;
  logic [2:0]       r_tag_vld;
  logic [2:0]       r_tag_id;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic       w_run;
  logic       w_gnt0;
  logic       w_gnt1;
  logic [1:0] w_inflight;
  logic [1:0] w_inflight_nxt;

  always_comb begin
    w_run          = !rst && (r_state == ST_RUN);
    w_gnt0         = w_run && bus.req0_valid && (!bus.req1_valid || !r_prio);
    w_gnt1         = w_run && bus.req1_valid && (!bus.req0_valid || r_prio);
    w_inflight     = {1'b0, r_tag_vld[0]} + {1'b0, r_tag_vld[1]} + {1'b0, r_tag_vld[2]};
    // Occupancy after the coming edge: lets idle rise in the same cycle inflight reaches 0.
    w_inflight_nxt = {1'b0, (w_gnt0 | w_gnt1)} + {1'b0, r_tag_vld[0]} + {1'b0, r_tag_vld[1]};
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign pipe_inst      = r_pipe_inst;
  assign done           = rst ? 2'b00 : {r_tag_vld[2] & r_tag_id[2], r_tag_vld[2] & ~r_tag_id[2]};
  assign inflight       = rst ? 2'd0 : w_inflight;
  assign idle           = !rst && r_idle;
  assign issued0_cnt    = r_cnt0;
  assign issued1_cnt    = r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_idle      <= 1'b0;
      r_prio      <= 1'b0;
      r_pipe_inst <= 8'h00;
      r_tag_vld   <= 3'b000;
      r_tag_id    <= 3'b000;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (drain && (w_inflight_nxt == 2'd0)) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
          end else if (drain) begin
            r_state <= ST_DRAIN;
            r_idle  <= 1'b0;
          end else begin
            r_idle  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!drain) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
          end else if (w_inflight_nxt == 2'd0) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
          end else begin
            r_idle  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (!drain) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
          end else begin
            r_idle  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_idle  <= 1'b0;
        end
      endcase

      if (w_gnt0) begin
        r_prio      <= 1'b1;
        r_pipe_inst <= bus.req0_inst;
        r_cnt0      <= r_cnt0 + CNT_W'(1);
      end else if (w_gnt1) begin
        r_prio      <= 1'b0;
        r_pipe_inst <= bus.req1_inst;
        r_cnt1      <= r_cnt1 + CNT_W'(1);
      end else begin
        r_pipe_inst <= 8'h00;
      end

      r_tag_vld <= {r_tag_vld[1:0], (w_gnt0 | w_gnt1)};
      r_tag_id  <= {r_tag_id[1:0], w_gnt1};
    end
  end

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Bench for pipe_issue_arbiter: directed vector table, randomized run against an issue-history model, counter wrap.
module tb_pipe_issue_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain = 1'b0;
  logic [7:0] pipe_inst;
  logic [1:0] done;
  logic       idle;
  logic [1:0] inflight;
  logic [7:0] issued0_cnt;
  logic [7:0] issued1_cnt;

  pipe_issue_arbiter_if bus ();

  pipe_issue_arbiter #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .drain       (drain),
    .pipe_inst   (pipe_inst),
    .done        (done),
    .idle        (idle),
    .inflight    (inflight),
    .issued0_cnt (issued0_cnt),
    .issued1_cnt (issued1_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int cyc;
    bit id;
  } issue_t;

  issue_t     m_iss[$];
  int         m_cyc = 0;
  bit         m_prev_rst = 1'b1;
  bit         m_prev_drain = 1'b0;
  bit         m_prio = 1'b0;
  logic [7:0] m_pipe = 8'h00;
  logic [7:0] m_cnt0 = 8'h00;
  logic [7:0] m_cnt1 = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, m_cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare on the falling edge, advance the model.
  task automatic step(input logic r, input logic v0, input logic [7:0] i0,
                      input logic v1, input logic [7:0] i1, input logic d);
    bit run, g0, g1, dn0, dn1, exp_idle;
    int infl;
    @(posedge clk);
    #1;
    rst = r;
    drain = d;
    bus.req0_valid = v0;
    bus.req0_inst  = i0;
    bus.req1_valid = v1;
    bus.req1_inst  = i1;
    #4;
    run = !r && (m_prev_rst || !m_prev_drain);
    g0  = run && v0 && (!v1 || !m_prio);
    g1  = run && v1 && (!v0 || m_prio);
    infl = 0;
    dn0 = 1'b0;
    dn1 = 1'b0;
    foreach (m_iss[j]) begin
      if (m_iss[j].cyc >= m_cyc - 3 && m_iss[j].cyc <= m_cyc - 1) infl++;
      if (m_iss[j].cyc == m_cyc - 3) begin
        if (m_iss[j].id) dn1 = 1'b1;
        else dn0 = 1'b1;
      end
    end
    if (r) begin
      infl = 0;
      dn0 = 1'b0;
      dn1 = 1'b0;
    end
    exp_idle = !r && !m_prev_rst && m_prev_drain && (infl == 0);

    check("ready",       32'({bus.req1_ready, bus.req0_ready}), 32'({g1, g0}));
    check("pipe_inst",   32'(pipe_inst),   32'(m_pipe));
    check("done",        32'(done),        32'({dn1, dn0}));
    check("inflight",    32'(inflight),    32'(infl));
    check("idle",        32'(idle),        32'(exp_idle));
    check("issued0_cnt", 32'(issued0_cnt), 32'(m_cnt0));
    check("issued1_cnt", 32'(issued1_cnt), 32'(m_cnt1));

    if (r) begin
      m_iss.delete();
      m_pipe = 8'h00;
      m_cnt0 = 8'h00;
      m_cnt1 = 8'h00;
      m_prio = 1'b0;
    end else if (g0) begin
      m_iss.push_back('{m_cyc, 1'b0});
      m_pipe = i0;
      m_cnt0 = m_cnt0 + 8'd1;
      m_prio = 1'b1;
    end else if (g1) begin
      m_iss.push_back('{m_cyc, 1'b1});
      m_pipe = i1;
      m_cnt1 = m_cnt1 + 8'd1;
      m_prio = 1'b0;
    end else begin
      m_pipe = 8'h00;
    end
    while (m_iss.size() > 0 && m_iss[0].cyc < m_cyc - 2) void'(m_iss.pop_front());
    m_prev_rst   = r;
    m_prev_drain = d;
    m_cyc++;
  endtask

  typedef struct {
    logic       r;
    logic       v0;
    logic [7:0] i0;
    logic       v1;
    logic [7:0] i1;
    logic       d;
    logic [1:0] rdy;
    logic [7:0] pipe;
    logic [1:0] dn;
    logic [1:0] infl;
    logic       idl;
  } vec_t;

  vec_t tbl[27];

  initial begin
    logic d_rand;
    bus.req0_valid = 1'b0;
    bus.req0_inst  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_inst  = 8'h00;

    //          r  v0  i0     v1  i1     d   rdy    pipe   done   infl  idle
    tbl[0]  = '{1, 1, 8'h46, 1, 8'h8A, 0, 2'b00, 8'h00, 2'b00, 2'd0, 0};
    tbl[1]  = '{1, 1, 8'h46, 1, 8'h8A, 0, 2'b00, 8'h00, 2'b00, 2'd0, 0};
    tbl[2]  = '{0, 1, 8'h46, 0, 8'h00, 0, 2'b01, 8'h00, 2'b00, 2'd0, 0};
    tbl[3]  = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h46, 2'b00, 2'd1, 0};
    tbl[4]  = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 2'b00, 2'd1, 0};
    tbl[5]  = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 2'b01, 2'd1, 0};
    tbl[6]  = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 2'b00, 2'd0, 0};
    tbl[7]  = '{0, 0, 8'h00, 1, 8'h9B, 0, 2'b10, 8'h00, 2'b00, 2'd0, 0};
    tbl[8]  = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b01, 8'h9B, 2'b00, 2'd1, 0};
    tbl[9]  = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b10, 8'h46, 2'b00, 2'd2, 0};
    tbl[10] = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b01, 8'hE7, 2'b10, 2'd3, 0};
    tbl[11] = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b10, 8'h46, 2'b01, 2'd3, 0};
    tbl[12] = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b01, 8'hE7, 2'b10, 2'd3, 0};
    tbl[13] = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b10, 8'h46, 2'b01, 2'd3, 0};
    tbl[14] = '{0, 1, 8'h46, 1, 8'hE7, 1, 2'b01, 8'hE7, 2'b10, 2'd3, 0};
    tbl[15] = '{0, 1, 8'h46, 1, 8'hE7, 1, 2'b00, 8'h46, 2'b01, 2'd3, 0};
    tbl[16] = '{0, 1, 8'h46, 1, 8'hE7, 1, 2'b00, 8'h00, 2'b10, 2'd2, 0};
    tbl[17] = '{0, 1, 8'h46, 1, 8'hE7, 1, 2'b00, 8'h00, 2'b01, 2'd1, 0};
    tbl[18] = '{0, 1, 8'h46, 1, 8'hE7, 1, 2'b00, 8'h00, 2'b00, 2'd0, 1};
    tbl[19] = '{0, 1, 8'h46, 1, 8'hE7, 1, 2'b00, 8'h00, 2'b00, 2'd0, 1};
    tbl[20] = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b00, 8'h00, 2'b00, 2'd0, 1};
    tbl[21] = '{0, 1, 8'h46, 1, 8'hE7, 0, 2'b10, 8'h00, 2'b00, 2'd0, 0};
    tbl[22] = '{0, 1, 8'h46, 0, 8'h00, 0, 2'b01, 8'hE7, 2'b00, 2'd1, 0};
    tbl[23] = '{1, 1, 8'h46, 1, 8'hE7, 0, 2'b00, 8'h46, 2'b00, 2'd0, 0};
    tbl[24] = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 2'b00, 2'd0, 0};
    tbl[25] = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 2'b00, 2'd0, 0};
    tbl[26] = '{0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 2'b00, 2'd0, 0};

    // Initial reset edge so every register is defined before the first comparison.
    @(posedge clk);

    for (int k = 0; k < 27; k++) begin
      step(tbl[k].r, tbl[k].v0, tbl[k].i0, tbl[k].v1, tbl[k].i1, tbl[k].d);
      check("tbl_ready",    32'({bus.req1_ready, bus.req0_ready}), 32'(tbl[k].rdy));
      check("tbl_pipe",     32'(pipe_inst), 32'(tbl[k].pipe));
      check("tbl_done",     32'(done),      32'(tbl[k].dn));
      check("tbl_inflight", 32'(inflight),  32'(tbl[k].infl));
      check("tbl_idle",     32'(idle),      32'(tbl[k].idl));
    end

    // Randomized traffic with sticky drain episodes and occasional reset.
    d_rand = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) d_rand = ~d_rand;
      step(($urandom_range(63) == 0), 1'($urandom), 8'($urandom),
           1'($urandom), 8'($urandom), d_rand);
    end

    // Counter wrap: 256 requester-1 handshakes from a clean reset.
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 8'(k), 1'b0);
      if (k == 128) check("wrap_mid_cnt1", 32'(issued1_cnt), 32'd128);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("wrap_cnt1", 32'(issued1_cnt), 32'd0);
    check("wrap_cnt0", 32'(issued0_cnt), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
